rf_writeback_queue: RTL and testbench

- Write-back buffer directly upstream of the 32x32 register file write port.
- Accepts (destination, data) results from execute/load via valid/ready.
- Buffers them in an in-order FIFO and drains at most one per cycle into the register file (write, dr, wrData).
- Forwards the youngest pending value for the two read addresses (sr1, sr2), so operand reads never see stale data while writes are queued.

---
 rtl/rf_writeback_queue_if.sv | 31 +++
 rtl/rf_writeback_queue.sv | 95 +++++++++
 tb/tb_rf_writeback_queue.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_queue_if.sv
// Producer / register-file-port bundle for the write-back queue.
// The queue sits on the slave side; the producer and regfile glue sit on the master side.
interface rf_writeback_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_dr;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          wr_en;
  logic [AW-1:0] wr_dr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] sr1;
  logic [AW-1:0] sr2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  modport master (
    output in_valid, in_dr, in_data, drain_en, sr1, sr2, rf_rd1, rf_rd2,
    input  in_ready, wr_en, wr_dr, wr_data, rd1, rd2
  );

  modport slave (
    input  in_valid, in_dr, in_data, drain_en, sr1, sr2, rf_rd1, rf_rd2,
    output in_ready, wr_en, wr_dr, wr_data, rd1, rd2
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order write-back FIFO in front of the register file write port, with youngest-entry read forwarding.
// Optional RF_WBQ_ZERO_REG_EN: register 0 is hardwired zero (not queued, reads as 0).
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  rf_writeback_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head, tail;
  logic [AW-1:0]    ent_dr   [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic             push, enq, pop;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;

`ifdef RF_WBQ_ZERO_REG_EN
  // Writes to r0 complete the handshake but are dropped.
  assign enq = push && (bus.in_dr != '0);
`else
  assign enq = push;
`endif

  // Reset suppresses the write so nothing pending leaks into the regfile.
  assign pop         = !empty && bus.drain_en && !reset;
  assign bus.wr_en   = pop;
  assign bus.wr_dr   = empty ? '0 : ent_dr[head];
  assign bus.wr_data = empty ? '0 : ent_data[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        head          <= head + PW'(1);
        ent_vld[head] <= 1'b0;
      end
      if (enq) begin
        tail          <= tail + PW'(1);
        ent_vld[tail] <= 1'b1;
      end
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_dr[tail]   <= bus.in_dr;
      ent_data[tail] <= bus.in_data;
    end
  end

  logic [1:0][AW-1:0] sr;
  logic [1:0][DW-1:0] rf, rd;

  assign sr[0]   = bus.sr1;
  assign sr[1]   = bus.sr2;
  assign rf[0]   = bus.rf_rd1;
  assign rf[1]   = bus.rf_rd2;
  assign bus.rd1 = rd[0];
  assign bus.rd2 = rd[1];

  // Scan oldest -> youngest from head so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      rd[p] = rf[p];
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PW'(k);
        if (ent_vld[idx] && ent_dr[idx] == sr[p])
          rd[p] = ent_data[idx];
      end
`ifdef RF_WBQ_ZERO_REG_EN
      if (sr[p] == '0)
        rd[p] = '0;
`endif
    end
  end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed self-checking bench for rf_writeback_queue (DEPTH=4, AW=5, DW=32).
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic       clk;
  logic       reset;
  logic [2:0] count;
  logic       full, empty;

  int checks = 0;
  int errs   = 0;

  rf_writeback_queue_if #(.AW(AW), .DW(DW)) bus ();

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] dr, input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_dr    = dr;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_dr    = '0;
    bus.in_data  = '0;
    bus.drain_en = 1'b0;
    bus.sr1      = '0;
    bus.sr2      = '0;
    bus.rf_rd1   = '0;
    bus.rf_rd2   = '0;
    tick();
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    reset = 1'b0;
    #1;

    // single push drains one cycle later
    bus.drain_en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_dr    = 5'd3;
    bus.in_data  = 32'hDEADBEEF;
    #1;
    chk("t1_no_bypass", 32'(bus.wr_en), 0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("t1_wr_en", 32'(bus.wr_en), 1);
    chk("t1_wr_dr", 32'(bus.wr_dr), 3);
    chk("t1_wr_data", bus.wr_data, 32'hDEADBEEF);
    chk("t1_count", 32'(count), 1);
    tick();
    chk("t1_empty", 32'(empty), 1);
    chk("t1_count0", 32'(count), 0);
    chk("t1_wr_en0", 32'(bus.wr_en), 0);
    chk("t1_wr_dr0", 32'(bus.wr_dr), 0);

    // fill while held (pointers start at 1, so tail wraps), then drain in order
    bus.drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 32'h11));
    chk("t2_full", 32'(full), 1);
    chk("t2_in_ready", 32'(bus.in_ready), 0);
    chk("t2_count", 32'(count), 4);
    push(5'd9, 32'h99);
    chk("t2_reject_count", 32'(count), 4);
    bus.sr1 = 5'd2;
    bus.sr2 = 5'd9;
    bus.rf_rd2 = 32'h1234;
    #1;
    chk("t2_fwd_r2", bus.rd1, 32'h22);
    chk("t2_not_enq_r9", bus.rd2, 32'h1234);
    bus.drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_drain_en", 32'(bus.wr_en), 1);
      chk("t2_drain_dr", 32'(bus.wr_dr), 32'(i));
      chk("t2_drain_data", bus.wr_data, 32'(i * 32'h11));
      tick();
    end
    chk("t2_empty", 32'(empty), 1);
    chk("t2_wr_en0", 32'(bus.wr_en), 0);

    // youngest of duplicate destinations is forwarded
    bus.drain_en = 1'b0;
    push(5'd5, 32'hA);
    push(5'd5, 32'hB);
    bus.sr1    = 5'd5;
    bus.rf_rd1 = 32'h0;
    bus.sr2    = 5'd6;
    bus.rf_rd2 = 32'h66;
    #1;
    chk("t3_young", bus.rd1, 32'hB);
    chk("t3_pass", bus.rd2, 32'h66);
    bus.drain_en = 1'b1;
    tick();
    bus.rf_rd1 = 32'hA;
    #1;
    chk("t3_head_fwd", bus.rd1, 32'hB);
    chk("t3_head_dr", 32'(bus.wr_dr), 5);
    tick();
    bus.drain_en = 1'b0;
    bus.rf_rd1   = 32'hB;
    #1;
    chk("t3_from_rf", bus.rd1, 32'hB);
    chk("t3_empty", 32'(empty), 1);

    // full with pop: no same-cycle refill, accepted next cycle
    for (int i = 0; i < 4; i++) push(5'(7 + i), 32'(32'h70 + i));
    bus.drain_en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_dr    = 5'd11;
    bus.in_data  = 32'hB0;
    #1;
    chk("t4_ready_full", 32'(bus.in_ready), 0);
    chk("t4_pop_dr", 32'(bus.wr_dr), 7);
    tick();
    chk("t4_count3", 32'(count), 3);
    chk("t4_ready", 32'(bus.in_ready), 1);
    chk("t4_pop_dr2", 32'(bus.wr_dr), 8);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_count_pp", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_drain_dr", 32'(bus.wr_dr), 32'(9 + i));
      chk("t4_drain_data", bus.wr_data, (i == 2) ? 32'hB0 : 32'(32'h72 + i));
      tick();
    end
    chk("t4_empty", 32'(empty), 1);

    // reset mid-operation discards pending writes
    bus.drain_en = 1'b0;
    for (int i = 0; i < 3; i++) push(5'(12 + i), 32'(32'hC0 + i));
    chk("t5_count", 32'(count), 3);
    bus.drain_en = 1'b1;
    reset = 1'b1;
    #1;
    chk("t5_rst_wr_en", 32'(bus.wr_en), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_count0", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_write", 32'(bus.wr_en), 0);
      tick();
    end

    // register 0 handling
    bus.drain_en = 1'b0;
    push(5'd0, 32'h55);
    bus.sr1    = 5'd0;
    bus.rf_rd1 = 32'h77;
    #1;
`ifdef RF_WBQ_ZERO_REG_EN
    chk("z_count", 32'(count), 0);
    chk("z_rd1", bus.rd1, 32'h0);
    bus.drain_en = 1'b1;
    #1;
    chk("z_no_wr", 32'(bus.wr_en), 0);
`else
    chk("z_count", 32'(count), 1);
    chk("z_rd1", bus.rd1, 32'h55);
    bus.drain_en = 1'b1;
    #1;
    chk("z_wr_en", 32'(bus.wr_en), 1);
    chk("z_wr_dr", 32'(bus.wr_dr), 0);
`endif
    tick();
    chk("z_empty", 32'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
